// File: rtl/i2c_rx_byte_buffer.sv
// I2C receive data path: shifts SDA bits MSB-first into words, stores them in a
// DEPTH-entry array and drives the ACK/NACK decision for each completed word.
module i2c_rx_byte_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned LEN_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          Abort,
  input  logic [LEN_WIDTH-1:0]          Length,
  input  logic                          BitStrobe,
  input  logic                          DIn,
  output logic [DEPTH*DATA_WIDTH-1:0]   Data,
  output logic [LEN_WIDTH-1:0]          ByteCount,
  output logic                          Busy,
  output logic                          Done,
  output logic                          AckValid,
  output logic                          AckBit
);

  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0]      LastBit  = CntW'(DATA_WIDTH - 1);
  localparam logic [LEN_WIDTH-1:0] DepthLen = LEN_WIDTH'(DEPTH);

  typedef enum logic [1:0] {StIdle, StShift, StAck, StDone} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-2:0] shift_q;
  logic [CntW-1:0]       bit_cnt_q;
  logic [IdxW-1:0]       idx_q;
  logic [LEN_WIDTH-1:0]  eff_len_q;

  logic [LEN_WIDTH-1:0]  len_clamped;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  last_word;

  always_comb begin
    len_clamped = (Length > DepthLen) ? DepthLen : Length;
    // Full word including the bit being sampled on this strobe.
    shifted     = {shift_q, DIn};
    last_word   = (LEN_WIDTH'(idx_q) == (eff_len_q - LEN_WIDTH'(1)));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      eff_len_q <= '0;
      Data      <= '0;
      ByteCount <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      AckValid  <= 1'b0;
      AckBit    <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            eff_len_q <= len_clamped;
            ByteCount <= '0;
            if (len_clamped == '0) begin
              state_q <= StDone;
              Done    <= 1'b1;
            end else begin
              state_q   <= StShift;
              Busy      <= 1'b1;
              Done      <= 1'b0;
              shift_q   <= '0;
              bit_cnt_q <= '0;
              idx_q     <= '0;
            end
          end
        end

        StShift: begin
          if (Abort) begin
            state_q <= StIdle;
            Busy    <= 1'b0;
          end else if (BitStrobe) begin
            shift_q   <= shifted[DATA_WIDTH-2:0];
            bit_cnt_q <= bit_cnt_q + CntW'(1);
            if (bit_cnt_q == LastBit) begin
              Data[idx_q*DATA_WIDTH +: DATA_WIDTH] <= shifted;
              ByteCount <= ByteCount + LEN_WIDTH'(1);
              state_q   <= StAck;
              AckValid  <= 1'b1;
              AckBit    <= last_word;
            end
          end
        end

        StAck: begin
          if (Abort) begin
            state_q  <= StIdle;
            Busy     <= 1'b0;
            AckValid <= 1'b0;
            AckBit   <= 1'b0;
          end else if (BitStrobe) begin
            // This strobe is the ACK clock slot; SDA is driven by us, not sampled.
            AckValid <= 1'b0;
            AckBit   <= 1'b0;
            if (last_word) begin
              state_q <= StDone;
              Busy    <= 1'b0;
              Done    <= 1'b1;
            end else begin
              state_q   <= StShift;
              idx_q     <= idx_q + IdxW'(1);
              bit_cnt_q <= '0;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_rx_byte_buffer.sv
// Directed self-checking bench for i2c_rx_byte_buffer (DATA_WIDTH=8, DEPTH=8).
module tb_i2c_rx_byte_buffer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Abort = 1'b0;
  logic [3:0]  Length = '0;
  logic        BitStrobe = 1'b0;
  logic        DIn = 1'b0;
  logic [63:0] Data;
  logic [3:0]  ByteCount;
  logic        Busy;
  logic        Done;
  logic        AckValid;
  logic        AckBit;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_rx_byte_buffer #(
    .DATA_WIDTH(8),
    .DEPTH     (8),
    .LEN_WIDTH (4)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Abort    (Abort),
    .Length   (Length),
    .BitStrobe(BitStrobe),
    .DIn      (DIn),
    .Data     (Data),
    .ByteCount(ByteCount),
    .Busy     (Busy),
    .Done     (Done),
    .AckValid (AckValid),
    .AckBit   (AckBit)
  );

  always #5 Clock = ~Clock;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input logic b);
    BitStrobe = 1'b1;
    DIn       = b;
    tick();
    BitStrobe = 1'b0;
    DIn       = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) pulse(w[i]);
  endtask

  task automatic check_ack(input string tag, input logic exp_bit, input logic [7:0] exp_word,
                           input int idx);
    check({tag, " ackvalid"}, {63'd0, AckValid}, 64'd1);
    check({tag, " ackbit"}, {63'd0, AckBit}, {63'd0, exp_bit});
    check({tag, " word"}, {56'd0, Data[idx*8 +: 8]}, {56'd0, exp_word});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, {63'd0, Busy}, 64'd0);
    check({tag, " done"}, {63'd0, Done}, 64'd0);
    check({tag, " ackvalid"}, {63'd0, AckValid}, 64'd0);
    check({tag, " ackbit"}, {63'd0, AckBit}, 64'd0);
  endtask

  initial begin
    // Reset state
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check_idle_outputs("reset");
    check("reset bytecount", {60'd0, ByteCount}, 64'd0);
    check("reset data", Data, 64'd0);

    // Strobes while idle must not shift anything into the first word
    pulse(1'b1);
    pulse(1'b1);
    pulse(1'b0);
    check("idle strobe busy", {63'd0, Busy}, 64'd0);

    // Three-word transfer with a stray Start (Length=0) mid-word
    Length = 4'd3;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    check("t1 busy", {63'd0, Busy}, 64'd1);
    check("t1 done low", {63'd0, Done}, 64'd0);
    send_word(8'hA5);
    check_ack("t1 w0", 1'b0, 8'hA5, 0);
    check("t1 w0 bytecount", {60'd0, ByteCount}, 64'd1);
    pulse(1'b0);
    check("t1 w0 ack drop", {63'd0, AckValid}, 64'd0);
    pulse(1'b0);  // 0x3C bit7
    pulse(1'b0);
    pulse(1'b1);
    Length = 4'd0;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    check("t1 start ignored busy", {63'd0, Busy}, 64'd1);
    check("t1 start ignored done", {63'd0, Done}, 64'd0);
    check("t1 start ignored count", {60'd0, ByteCount}, 64'd1);
    pulse(1'b1);  // remaining bits of 0x3C: 1 1 1 0 0
    pulse(1'b1);
    pulse(1'b1);
    pulse(1'b0);
    pulse(1'b0);
    check_ack("t1 w1", 1'b0, 8'h3C, 1);
    pulse(1'b0);
    send_word(8'hFF);
    check_ack("t1 w2", 1'b1, 8'hFF, 2);
    pulse(1'b0);
    check("t1 done", {63'd0, Done}, 64'd1);
    check("t1 busy end", {63'd0, Busy}, 64'd0);
    check("t1 bytecount", {60'd0, ByteCount}, 64'd3);
    check("t1 data", Data, 64'h0000_0000_00FF_3CA5);
    tick();
    check("t1 done holds", {63'd0, Done}, 64'd1);

    // Zero-length transfer
    Length = 4'd0;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    check("zl done", {63'd0, Done}, 64'd1);
    check("zl busy", {63'd0, Busy}, 64'd0);
    check("zl bytecount", {60'd0, ByteCount}, 64'd0);
    check("zl data kept", Data, 64'h0000_0000_00FF_3CA5);

    // Length clamped from 15 to 8
    Length = 4'd15;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    check("cl done low", {63'd0, Done}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      send_word(8'(k + 1));
      check_ack("cl", (k == 7), 8'(k + 1), k);
      pulse(1'b0);
    end
    check("cl done", {63'd0, Done}, 64'd1);
    check("cl bytecount", {60'd0, ByteCount}, 64'd8);
    check("cl data", Data, 64'h0807_0605_0403_0201);

    // Abort after one word plus five bits; final strobe collides with Abort
    Length = 4'd4;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    send_word(8'h5A);
    check_ack("ab w0", 1'b0, 8'h5A, 0);
    pulse(1'b0);
    for (int i = 0; i < 4; i++) pulse(1'b1);
    Abort = 1'b1;
    pulse(1'b1);
    Abort = 1'b0;
    check_idle_outputs("ab");
    check("ab bytecount", {60'd0, ByteCount}, 64'd1);
    check("ab data", Data, 64'h0807_0605_0403_025A);
    for (int i = 0; i < 8; i++) pulse(1'b1);
    check("ab idle strobes data", Data, 64'h0807_0605_0403_025A);
    check("ab idle strobes busy", {63'd0, Busy}, 64'd0);

    // Reset during the ACK of the second word
    Length = 4'd3;
    Start  = 1'b1;
    tick();
    Start  = 1'b0;
    send_word(8'h11);
    pulse(1'b0);
    send_word(8'h22);
    check_ack("rs w1", 1'b0, 8'h22, 1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_idle_outputs("rs");
    check("rs bytecount", {60'd0, ByteCount}, 64'd0);
    check("rs data", Data, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_rx_byte_buffer.md
Name: i2c_rx_byte_buffer

Overview:
Parametrised successor to the I2C receive data path. It shifts serial SDA bits MSB-first into bytes, qualified by a single-cycle bit strobe derived from SCL in the main clock domain. Completed bytes are written into an internal DEPTH-entry array, and the block tells the bus master whether to ACK or NACK each byte. It sits between the I2C bit-level controller (which supplies BitStrobe/DIn and consumes AckValid/AckBit) and the register/host side (which reads Data after Done).

Parameters:
DATA_WIDTH, 8, bits per received word.
DEPTH, 8, number of words in the receive array.
LEN_WIDTH, $clog2(DEPTH+1), width of Length and ByteCount.

Ports:
Clock  input  1  single system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Start  input  1  one-cycle pulse; latches Length and begins a read transfer. Honoured only in IDLE or DONE.
Abort  input  1  one-cycle pulse; terminates the transfer (bus error or STOP seen).
Length  input  LEN_WIDTH  number of words to receive.
BitStrobe  input  1  one-cycle pulse per SCL rising edge; DIn is sampled only when it is high.
DIn  input  1  SDA sample.
Data  output  DEPTH*DATA_WIDTH  flat array; word i is at [i*DATA_WIDTH +: DATA_WIDTH].
ByteCount  output  LEN_WIDTH  words completed in the current/last transfer.
Busy  output  1  high in SHIFT or ACK.
Done  output  1  level; high in DONE.
AckValid  output  1  high in ACK; AckBit is valid while it is high.
AckBit  output  1  0 = ACK (more words follow), 1 = NACK (last word).

Behaviour:
- Reset: state=IDLE. Data=0, ByteCount=0, Busy=0, Done=0, AckValid=0, AckBit=0. Internal shift register, bit counter, index and latched length are all 0.
- Length latch: eff_len = min(Length, DEPTH), captured on the accepted Start.
- States: IDLE, SHIFT, ACK, DONE.
- IDLE/DONE, Start=1:
  - eff_len==0 -> DONE next cycle, ByteCount=0.
  - otherwise -> SHIFT; ByteCount=0, bit counter=0, index=0, Done falls.
  - Data is not cleared.
- SHIFT, on each BitStrobe: shift_reg <= {shift_reg[DATA_WIDTH-2:0], DIn}; bit counter increments.
  - On the DATA_WIDTH-th strobe, the next state is ACK.
  - Data[index] <= the completed word (including the final DIn) on that same edge, so the word is visible the cycle AckValid rises.
  - ByteCount increments on that same edge.
- ACK: AckValid=1. AckBit=1 if index==eff_len-1, else 0. AckBit is registered on entry and stable throughout ACK.
  - The next BitStrobe (the ACK clock slot) is consumed, not shifted.
  - Then: if last word -> DONE; else index++, bit counter=0 -> SHIFT.
- DONE: Done=1 and holds until an accepted Start or Reset.
- Latency: AckValid rises 1 Clock after the DATA_WIDTH-th BitStrobe. Done rises 1 Clock after the final ACK-slot BitStrobe.
- Abort in SHIFT or ACK:
  - Next state IDLE; Busy, AckValid and Done are 0.
  - The partial word is discarded. Data and ByteCount keep the completed words.
  - Abort in IDLE/DONE: no effect.
- Simultaneous events:
  - Abort and BitStrobe together: Abort wins; no shift, no write.
  - Start and Abort together in IDLE/DONE: Start wins.
  - Start while Busy: ignored.
- BitStrobe in IDLE/DONE: ignored.
- Reset has priority over everything, including mid-word; it clears Data.
- Index never exceeds DEPTH-1 because of the clamp; there are no out-of-range writes.

Test Plan:
- Reset then Start with Length=3. Serial bytes 0xA5, 0x3C, 0xFF MSB-first -> AckBit sequence 0, 0, 1. Data word0=0xA5, word1=0x3C, word2=0xFF. ByteCount=3. Done=1 one cycle after the 27th strobe.
- Start with Length=0 -> Done=1 on the next cycle, Busy never high, ByteCount=0, Data unchanged.
- Length=15 with DEPTH=8 -> clamped to 8. Receive 8 words 0x01..0x08 -> NACK on word 8, all 8 words stored, ByteCount=8.
- Length=4; Abort after word 1 plus 5 bits of word 2 -> IDLE, Done=0, word0 valid, ByteCount=1, word1 unchanged from its prior value.
- Start pulsed mid-transfer, and BitStrobe pulses while IDLE -> no state change, no shifting; the transfer completes normally.
- Reset asserted during ACK of word 2 -> next cycle all outputs at reset values, Data all zeros.
